// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the MEM-stage data memory arbiter.
// Pure definitions: no logic, no latency, no flow control.
package cpu_mem_pkg;

  typedef enum logic {IDLE, VBURST} arb_state_t;
  typedef enum logic {SCALAR, VECTOR} requester_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_VLEN   = 4;
  localparam int DEF_BEAT_W = $clog2(DEF_VLEN);

endpackage

// File: rtl/vec_gather_reg.sv
// VLEN x DATA_W gather register: one element written per cycle at cap_idx.
// Write lands on the next rising edge; always accepts, no backpressure.
module vec_gather_reg
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int VLEN   = DEF_VLEN,
  localparam int IDX_W = $clog2(VLEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          cap_en,
  input  logic [IDX_W-1:0]              cap_idx,
  input  logic [DATA_W-1:0]             cap_dat,
  output logic [VLEN-1:0][DATA_W-1:0]   q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (cap_en) begin
      q[cap_idx] <= cap_dat;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data RAM port between scalar single-beat and vector VLEN-beat accesses.
// Grants are combinational in IDLE; read data returns one cycle after issue; losers see stall.
module data_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int VLEN   = DEF_VLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_req,
  input  logic                     s_we,
  input  logic [ADDR_W-1:0]        s_addr,
  input  logic [DATA_W-1:0]        s_wdata,
  output logic                     s_gnt,
  output logic                     s_rvalid,
  output logic [DATA_W-1:0]        s_rdata,
  input  logic                     v_req,
  input  logic                     v_we,
  input  logic [ADDR_W-1:0]        v_addr,
  input  logic [VLEN*DATA_W-1:0]   v_wdata,
  output logic                     v_gnt,
  output logic                     v_done,
  output logic [VLEN*DATA_W-1:0]   v_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     stall
);

  localparam int BW = $clog2(VLEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(VLEN - 1);

  arb_state_t                  state;
  requester_t                  rr_last;
  logic [BW-1:0]               beat;
  logic                        vq_we;
  logic [ADDR_W-1:0]           vq_addr;
  logic [VLEN-1:0][DATA_W-1:0] vq_wdata;
  logic [VLEN-1:0][DATA_W-1:0] v_wdata_a;
  logic [VLEN-1:0][DATA_W-1:0] gath_q;
  logic [VLEN-1:0][DATA_W-1:0] v_rdata_w;
  logic                        cap_vld;
  logic [BW-1:0]               cap_idx;
  logic                        v_issue;
  logic [BW-1:0]               issue_beat;
  logic                        idle;

  assign v_wdata_a = v_wdata;

  // Gating with ~rst keeps every combinational output at 0 while reset is held.
  assign idle  = ~rst & (state == IDLE);
  assign s_gnt = idle & s_req & (~v_req | (rr_last == VECTOR));
  assign v_gnt = idle & v_req & (~s_req | (rr_last == SCALAR));
  assign stall = ~rst & ((s_req & ~s_gnt) | (v_req & ~v_gnt) | (state == VBURST));
  assign s_rdata = s_rvalid ? mem_rdata : '0;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    v_issue    = 1'b0;
    issue_beat = '0;
    if (s_gnt) begin
      mem_en    = 1'b1;
      mem_we    = s_we;
      mem_addr  = s_addr;
      mem_wdata = s_wdata;
    end else if (v_gnt) begin
      mem_en    = 1'b1;
      mem_we    = v_we;
      mem_addr  = v_addr;
      mem_wdata = v_wdata_a[0];
      v_issue   = 1'b1;
    end else if (state == VBURST) begin
      mem_en     = 1'b1;
      mem_we     = vq_we;
      mem_addr   = vq_addr + ADDR_W'(beat);
      mem_wdata  = vq_wdata[beat];
      v_issue    = 1'b1;
      issue_beat = beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_last  <= VECTOR;
      beat     <= '0;
      vq_we    <= 1'b0;
      vq_addr  <= '0;
      vq_wdata <= '0;
      s_rvalid <= 1'b0;
      v_done   <= 1'b0;
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
    end else begin
      s_rvalid <= s_gnt & ~s_we;
      cap_vld  <= v_issue & ~mem_we;
      cap_idx  <= issue_beat;
      v_done   <= (state == VBURST) && (beat == LAST_BEAT);
      case (state)
        IDLE: begin
          if (s_gnt) begin
            rr_last <= SCALAR;
          end else if (v_gnt) begin
            rr_last  <= VECTOR;
            vq_we    <= v_we;
            vq_addr  <= v_addr;
            vq_wdata <= v_wdata_a;
            beat     <= BW'(1);
            state    <= VBURST;
          end
        end
        VBURST: begin
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= IDLE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vec_gather_reg #(
    .DATA_W (DATA_W),
    .VLEN   (VLEN)
  ) u_gather (
    .clk     (clk),
    .rst     (rst),
    .clr     (1'b0),
    .cap_en  (cap_vld),
    .cap_idx (cap_idx),
    .cap_dat (mem_rdata),
    .q       (gath_q)
  );

  // Forward the element returning this cycle so v_rdata is complete alongside v_done.
  always_comb begin
    v_rdata_w = gath_q;
    if (cap_vld) v_rdata_w[cap_idx] = mem_rdata;
  end

  assign v_rdata = v_rdata_w;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 1-cycle-latency RAM model and
// scoreboard queues for scalar and vector read returns.
module tb_data_mem_arbiter;

  localparam logic [31:0] EA = 32'hAAAA_0001;
  localparam logic [31:0] EB = 32'hBBBB_0002;
  localparam logic [31:0] EC = 32'hCCCC_0003;
  localparam logic [31:0] ED = 32'hDDDD_0004;
  localparam logic [127:0] V1234 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] VDCBA = {ED, EC, EB, EA};

  logic         clk;
  logic         rst;
  logic         s_req, s_we;
  logic [15:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         s_gnt, s_rvalid;
  logic [31:0]  s_rdata;
  logic         v_req, v_we;
  logic [15:0]  v_addr;
  logic [127:0] v_wdata;
  logic         v_gnt, v_done;
  logic [127:0] v_rdata;
  logic         mem_en, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         stall;

  logic [31:0]  ram [0:65535];
  logic         tb_load;
  logic [15:0]  ea;

  int errors = 0;
  int checks = 0;
  logic [31:0]  exp_s[$];
  logic [127:0] exp_v[$];

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_gnt(v_gnt), .v_done(v_done), .v_rdata(v_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_load) begin
      ram[16'h0010] <= 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) ram[16'h0100 + 16'(k)] <= 32'(k + 1);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and retire any read return against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    if (s_rvalid) begin
      if (exp_s.size() == 0) chk("s_rvalid_unexpected", s_rvalid, 1'b0);
      else chk("s_rdata", s_rdata, exp_s.pop_front());
    end
    if (v_done) begin
      if (exp_v.size() == 0) chk("v_done_unexpected", v_done, 1'b0);
      else chk("v_rdata", v_rdata, exp_v.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; tb_load = 1'b1;
    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
    repeat (2) @(posedge clk);
    #2;
    tb_load = 1'b0;
    s_req = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_s_gnt", s_gnt, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_s_rvalid", s_rvalid, 1'b0);
    chk("rst_v_done", v_done, 1'b0);
    chk("rst_v_rdata", v_rdata, 128'd0);
    s_req = 1'b0;
    step();
    rst = 1'b0;

    // Scalar read alone
    s_req = 1; s_we = 0; s_addr = 16'h0010;
    #1;
    chk("sr_s_gnt", s_gnt, 1'b1);
    chk("sr_mem_en", mem_en, 1'b1);
    chk("sr_mem_we", mem_we, 1'b0);
    chk("sr_mem_addr", mem_addr, 16'h0010);
    chk("sr_stall", stall, 1'b0);
    exp_s.push_back(32'hDEADBEEF);
    step();
    s_req = 0;
    #1;
    chk("sr_rvalid", s_rvalid, 1'b1);
    chk("sr_stall_after", stall, 1'b0);

    // Vector read
    v_req = 1; v_we = 0; v_addr = 16'h0100;
    #1;
    chk("vr_v_gnt", v_gnt, 1'b1);
    chk("vr_addr0", mem_addr, 16'h0100);
    chk("vr_stall0", stall, 1'b0);
    exp_v.push_back(V1234);
    step();
    v_req = 0;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("vr_addr", mem_addr, 16'h0100 + 16'(i));
      chk("vr_stall", stall, 1'b1);
      chk("vr_no_regrant", v_gnt, 1'b0);
      step();
    end
    #1;
    chk("vr_done", v_done, 1'b1);
    chk("vr_done_stall", stall, 1'b0);
    chk("vr_done_mem_en", mem_en, 1'b0);
    step();
    chk("vr_done_pulse", v_done, 1'b0);

    // Tie after reset: scalar first, then vector
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_req = 1; s_we = 1; s_addr = 16'h0020; s_wdata = 32'h5555_5555;
    v_req = 1; v_we = 0; v_addr = 16'h0100;
    #1;
    chk("tie1_s_gnt", s_gnt, 1'b1);
    chk("tie1_v_gnt", v_gnt, 1'b0);
    chk("tie1_stall", stall, 1'b1);
    step();
    s_req = 0;
    #1;
    chk("tie1_v_gnt_next", v_gnt, 1'b1);
    chk("tie1_v_addr", mem_addr, 16'h0100);
    chk("tie1_v_stall", stall, 1'b0);
    exp_v.push_back(V1234);
    step();
    v_req = 0;
    repeat (3) step();
    chk("tie1_s_write", ram[16'h0020], 32'h5555_5555);

    // Second tie in the v_done cycle; vector side is a wrapping write
    s_req = 1; s_we = 0; s_addr = 16'h0010;
    v_req = 1; v_we = 1; v_addr = 16'hFFFE; v_wdata = VDCBA;
    #1;
    chk("tie2_s_gnt", s_gnt, 1'b1);
    chk("tie2_v_gnt", v_gnt, 1'b0);
    exp_s.push_back(32'hDEADBEEF);
    step();
    s_req = 0;
    #1;
    chk("wr_v_gnt", v_gnt, 1'b1);
    exp_v.push_back(V1234);
    for (int i = 0; i < 4; i++) begin
      #1;
      ea = 16'hFFFE + 16'(i);
      chk("wr_mem_we", mem_we, 1'b1);
      chk("wr_mem_addr", mem_addr, ea);
      step();
      v_req = 0;
    end
    chk("wrap_ram_fffe", ram[16'hFFFE], EA);
    chk("wrap_ram_ffff", ram[16'hFFFF], EB);
    chk("wrap_ram_0000", ram[16'h0000], EC);
    chk("wrap_ram_0001", ram[16'h0001], ED);

    // Back-to-back: scalar write waits behind a vector read burst
    v_req = 1; v_we = 0; v_addr = 16'hFFFE;
    #1;
    chk("b2b_v_gnt", v_gnt, 1'b1);
    exp_v.push_back(VDCBA);
    step();
    v_req = 0;
    s_req = 1; s_we = 1; s_addr = 16'h0030; s_wdata = 32'h1234_5678;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("b2b_s_wait", s_gnt, 1'b0);
      chk("b2b_stall", stall, 1'b1);
      step();
    end
    #1;
    chk("b2b_s_gnt", s_gnt, 1'b1);
    chk("b2b_v_done", v_done, 1'b1);
    chk("b2b_stall_done", stall, 1'b0);
    chk("b2b_mem_addr", mem_addr, 16'h0030);
    chk("b2b_mem_we", mem_we, 1'b1);
    step();
    s_req = 0;
    chk("b2b_ram", ram[16'h0030], 32'h1234_5678);

    // Reset in the middle of a vector read
    v_req = 1; v_we = 0; v_addr = 16'h0100;
    #1;
    chk("mid_v_gnt", v_gnt, 1'b1);
    step();
    v_req = 0;
    #1;
    chk("mid_beat1_addr", mem_addr, 16'h0101);
    step();
    rst = 1'b1;
    #1;
    chk("mid_mem_en", mem_en, 1'b0);
    chk("mid_v_rdata", v_rdata, 128'd0);
    chk("mid_stall", stall, 1'b0);
    step();
    rst = 1'b0;
    repeat (3) begin
      step();
      #1;
      chk("mid_no_v_done", v_done, 1'b0);
      chk("mid_no_s_rvalid", s_rvalid, 1'b0);
    end
    v_req = 1; v_addr = 16'h0100;
    #1;
    chk("restart_v_gnt", v_gnt, 1'b1);
    chk("restart_addr", mem_addr, 16'h0100);
    exp_v.push_back(V1234);
    step();
    v_req = 0;
    repeat (3) step();
    chk("restart_v_rdata", v_rdata, V1234);
    step();
    chk("sb_empty", 128'(exp_s.size() + exp_v.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between the scalar load/store path and the vector load/store path.
- The scalar path issues single-beat accesses. The vector path issues VLEN-beat bursts, one element per cycle.
- Grants the port, sequences vector beats, gathers vector read data and raises a pipeline stall while a requester waits or a vector burst is in flight.
- Sits in the MEM stage between the pipeline register and data RAM; its requests are driven by write_memory_enable_a/_b and the load decode.

Parameters:
DATA_W, 32, element/word width in bits
ADDR_W, 16, word address width
VLEN, 4, elements per vector (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
s_req  in  1  scalar access request
s_we  in  1  scalar write (1) / read (0)
s_addr  in  ADDR_W  scalar word address
s_wdata  in  DATA_W  scalar write data
s_gnt  out  1  scalar access issued this cycle
s_rvalid  out  1  scalar read data valid
s_rdata  out  DATA_W  scalar read data
v_req  in  1  vector access request
v_we  in  1  vector write/read
v_addr  in  ADDR_W  vector base word address
v_wdata  in  VLEN*DATA_W  vector write data, element i at bits [i*DATA_W +: DATA_W]
v_gnt  out  1  vector burst accepted (beat 0 issued)
v_done  out  1  vector burst complete pulse
v_rdata  out  VLEN*DATA_W  gathered vector read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
stall  out  1  freeze pipeline upstream of MEM

Behaviour:
- Reset values: state IDLE, beat counter 0, rr_last=VECTOR (scalar wins the first tie), all outputs 0, v_rdata 0.
- States: IDLE, VBURST.
- Handshake: each request is held high with stable payload until its gnt. The arbiter latches the vector payload (we, addr, wdata) at v_gnt. v_req may drop after v_gnt.

IDLE arbitration (combinational grant):
- Only s_req: s_gnt=1; mem_en=1, mem_we=s_we, mem_addr=s_addr, mem_wdata=s_wdata; rr_last<=SCALAR; stay IDLE.
- Only v_req: v_gnt=1; beat 0 issued from live v_* inputs; beat<=1; rr_last<=VECTOR; go VBURST.
- Both: grant the one not equal to rr_last; the loser waits.

VBURST:
- Issues beat i = counter; mem_addr = base + i (mod 2^ADDR_W, wraps); mem_wdata = element i; mem_we = latched we.
- The last beat issues when counter = VLEN-1, then the state returns to IDLE.
- No other grant is issued during VBURST.

Read return:
- Scalar: s_rvalid=1 and s_rdata=mem_rdata in the cycle after a scalar read grant. No s_rvalid for writes.
- Vector: mem_rdata is captured into element i the cycle after beat i issues.
- v_done pulses one cycle after the last beat, for reads and writes alike.
- v_rdata holds until the next vector read captures over it.
- In the v_done cycle the arbiter is IDLE and may grant a new access (back-to-back, zero bubble).

Stall:
- stall = (s_req & ~s_gnt) | (v_req & ~v_gnt) | (state==VBURST).
- stall is low in the v_done cycle unless a new request loses arbitration.

Throughput:
- Scalar accesses issue one per cycle when alone.
- A vector burst occupies exactly VLEN consecutive cycles.

Reset mid-burst:
- Outputs and state clear immediately (asynchronous).
- No v_done, no s_rvalid after release. Partial v_rdata is cleared.

Decomposition:
- Package cpu_mem_pkg: arb_state_t enum {IDLE, VBURST}; requester_t enum {SCALAR, VECTOR}; default DATA_W/ADDR_W/VLEN localparams; beat counter width $clog2(VLEN).
- Sub-module vec_gather_reg: VLEN x DATA_W register with indexed capture enable, synchronous clear and asynchronous reset. Holds v_rdata.

Test Plan:
- Scalar read alone: s_req=1, s_we=0, s_addr=0x0010, RAM[0x10]=0xDEADBEEF. Required: s_gnt the same cycle, mem_addr=0x0010, s_rvalid with s_rdata=0xDEADBEEF the next cycle, stall=0 throughout.
- Vector read, VLEN=4: v_addr=0x0100, RAM[0x100..0x103]=1,2,3,4. Required: v_gnt at cycle 0, mem_addr 0x100..0x103 on cycles 0-3, v_done at cycle 4, v_rdata={4,3,2,1}, stall=1 on cycles 1-3.
- Tie after reset: s_req and v_req both high at cycle 0. Required: scalar granted first, vector granted at cycle 1. A second simultaneous tie after the vector burst grants scalar.
- Address wrap: vector write with v_addr=0xFFFE, elements A,B,C,D. Required: RAM[0xFFFE]=A, [0xFFFF]=B, [0x0000]=C, [0x0001]=D, and mem_we=1 on all four beats.
- Back-to-back: scalar write arrives during a vector burst. Required: the scalar waits with stall=1, then s_gnt in the v_done cycle with no idle cycle between bursts.
- Reset mid-burst: rst asserted after beat 1. Required: mem_en=0 immediately, no v_done, v_rdata=0, state IDLE, and a new v_req after release restarts from beat 0.
